// File: rtl/phy_rx_deframer.sv
// Receive deframer for the PHY nibble stream: strips preamble/SFD, rebuilds bytes
// low nibble first, and reports per-frame start/end/length/error plus a good-frame sequence count.
module phy_rx_deframer #(
    parameter int PRE_MIN_NIB = 7,
    parameter int MIN_LEN     = 64,
    parameter int MAX_LEN     = 2047
) (
    input  logic        clk_phy,
    input  logic        reset,
    input  logic [3:0]  phy_rx_data,
    input  logic        phy_rx_en,
    output logic [7:0]  r_data_out,
    output logic        r_data_valid,
    output logic        r_frame_start,
    output logic        r_frame_end,
    output logic [11:0] r_frame_len,
    output logic        r_err,
    output logic [3:0]  r_frame_seq
);

    localparam logic [3:0]  PRE_MIN_C = 4'(PRE_MIN_NIB);
    localparam logic [11:0] MIN_LEN_C = 12'(MIN_LEN);
    localparam logic [11:0] MAX_LEN_C = 12'(MAX_LEN);
    localparam logic [3:0]  NIB_PRE   = 4'h5;
    localparam logic [3:0]  NIB_SFD   = 4'hD;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        DATA_LO,
        DATA_HI,
        DROP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  pre_cnt_q, pre_cnt_d;
    logic [11:0] byte_cnt_q, byte_cnt_d;
    logic [3:0]  lo_q, lo_d;
    // Low until the first edge after reset, so a burst already in flight at release is dropped.
    logic        armed_q;

    logic [7:0]  data_d;
    logic        valid_d;
    logic        start_d;
    logic        end_d;
    logic [11:0] len_d;
    logic        err_d;
    logic [3:0]  seq_d;

    always_ff @(posedge clk_phy or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            pre_cnt_q     <= 4'd0;
            byte_cnt_q    <= 12'd0;
            lo_q          <= 4'd0;
            armed_q       <= 1'b0;
            r_data_out    <= 8'd0;
            r_data_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_frame_len   <= 12'd0;
            r_err         <= 1'b0;
            r_frame_seq   <= 4'd0;
        end else begin
            state_q       <= state_d;
            pre_cnt_q     <= pre_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            lo_q          <= lo_d;
            armed_q       <= 1'b1;
            r_data_out    <= data_d;
            r_data_valid  <= valid_d;
            r_frame_start <= start_d;
            r_frame_end   <= end_d;
            r_frame_len   <= len_d;
            r_err         <= err_d;
            r_frame_seq   <= seq_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        byte_cnt_d = byte_cnt_q;
        lo_d       = lo_q;
        data_d     = r_data_out;
        valid_d    = 1'b0;
        start_d    = 1'b0;
        end_d      = 1'b0;
        len_d      = r_frame_len;
        err_d      = r_err;
        seq_d      = r_frame_seq;

        case (state_q)
            IDLE: begin
                if (phy_rx_en) begin
                    if (armed_q && phy_rx_data == NIB_PRE) begin
                        state_d   = PREAMBLE;
                        pre_cnt_d = 4'd1;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            PREAMBLE: begin
                if (!phy_rx_en) begin
                    state_d = IDLE;
                end else if (phy_rx_data == NIB_PRE) begin
                    pre_cnt_d = (pre_cnt_q == 4'd15) ? 4'd15 : pre_cnt_q + 4'd1;
                end else if (phy_rx_data == NIB_SFD && pre_cnt_q >= PRE_MIN_C) begin
                    state_d    = DATA_LO;
                    byte_cnt_d = 12'd0;
                end else begin
                    state_d = DROP;
                end
            end
            DATA_LO: begin
                if (phy_rx_en) begin
                    lo_d    = phy_rx_data;
                    state_d = DATA_HI;
                end else begin
                    state_d = IDLE;
                    end_d   = 1'b1;
                    len_d   = byte_cnt_q;
                    err_d   = (byte_cnt_q < MIN_LEN_C);
                    if (byte_cnt_q >= MIN_LEN_C) begin
                        seq_d = r_frame_seq + 4'd1;
                    end
                end
            end
            DATA_HI: begin
                if (phy_rx_en) begin
                    if (byte_cnt_q == MAX_LEN_C) begin
                        // Overflowing byte is swallowed; the frame is closed as bad right here.
                        state_d = DROP;
                        end_d   = 1'b1;
                        len_d   = MAX_LEN_C;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = DATA_LO;
                        data_d     = {phy_rx_data, lo_q};
                        valid_d    = 1'b1;
                        start_d    = (byte_cnt_q == 12'd0);
                        byte_cnt_d = byte_cnt_q + 12'd1;
                    end
                end else begin
                    state_d = IDLE;
                    end_d   = 1'b1;
                    len_d   = byte_cnt_q;
                    err_d   = 1'b1;
                end
            end
            DROP: begin
                if (!phy_rx_en) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
